// File: rtl/d_trig_pkg.sv
// Shared constants for the d_trig storage cell family.
`timescale 1ns/1ps

package d_trig_pkg;

  // Smallest legal register width; a zero-width register has no meaning.
  localparam int MIN_WIDTH = 1;

  // Reset value of a single cell when none is given.
  localparam logic CELL_RST_DEFAULT = 1'b0;

endpackage : d_trig_pkg

// File: rtl/d_trig_cell.sv
// One-bit rising-edge D flip-flop with asynchronous active-low reset and a
// complementary output derived from the stored bit.
`timescale 1ns/1ps

module d_trig_cell
  import d_trig_pkg::*;
#(
  parameter logic RST_VAL = CELL_RST_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic qn
);

  // Capture d on each rising clock edge; reset forces RST_VAL immediately.
  // NOTE: reset is in the sensitivity list so it acts without a clock edge,
  // and state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

  // Complement is pure wiring from the stored bit, so q and qn can never
  // agree, not even during reset.
  assign qn = ~q;

endmodule : d_trig_cell

// File: rtl/d_trig.sv
// WIDTH independent D flip-flops sharing clock C and asynchronous reset Rn.
// Each bit is its own d_trig_cell; the top only checks parameters and wires.
`timescale 1ns/1ps

module d_trig
  import d_trig_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             C,
  input  logic             Rn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  // Reject a width that cannot hold any state at elaboration time.
  if (WIDTH < MIN_WIDTH) begin : g_bad_width
    $error("d_trig: WIDTH must be at least %0d", MIN_WIDTH);
  end

  // One cell per bit; no state is shared between bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    d_trig_cell #(
      .RST_VAL (RST_VAL[i])
    ) u_cell (
      .clk   (C),
      .rst_n (Rn),
      .d     (D[i]),
      .q     (Q[i]),
      .qn    (Qn[i])
    );
  end

endmodule : d_trig

// File: tb/tb_d_trig.sv
// Self-checking bench for d_trig: three instances (4-bit reset 0, 4-bit
// reset 9, 1-bit default) share C, Rn and D. A driver issues one stimulus
// cycle per clock period and queues the expected response; monitors pop and
// compare at each rising edge, on falling edges, and on reset assertion.
`timescale 1ns/1ps

module tb_d_trig;

  localparam int             W     = 4;
  localparam logic [W-1:0]   RST_B = 4'h9;

  logic         C = 1'b0;
  logic         Rn;
  logic [W-1:0] D;

  logic [W-1:0] qa, qna, qb, qnb;
  logic [0:0]   qc, qnc;

  d_trig #(.WIDTH(W)) dut_a (.C(C), .Rn(Rn), .D(D), .Q(qa), .Qn(qna));
  d_trig #(.WIDTH(W), .RST_VAL(RST_B)) dut_b (.C(C), .Rn(Rn), .D(D), .Q(qb), .Qn(qnb));
  d_trig dut_c (.C(C), .Rn(Rn), .D(D[0:0]), .Q(qc), .Qn(qnc));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
  } exp_t;

  exp_t edge_q[$];
  exp_t async_q[$];
  exp_t held;
  bit   held_valid = 0;
  bit   done = 0;

  int n_vec  = 0;
  int n_miss = 0;

  // Period 100 ns, first rising edge at 50 ns.
  initial begin
    #50;
    forever begin
      C = 1'b1; #50;
      C = 1'b0; #50;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference behaviour: an active reset yields the reset value, otherwise
  // the stored word is the D value present at the edge.
  function automatic exp_t model(input logic rn, input logic [W-1:0] d);
    exp_t e;
    if (rn) begin
      e.a = d;
      e.b = d;
      e.c = d[0];
    end else begin
      e.a = '0;
      e.b = RST_B;
      e.c = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, "_qa"},  qa,  e.a);
    check({tag, "_qna"}, qna, ~e.a);
    check({tag, "_qb"},  qb,  e.b);
    check({tag, "_qnb"}, qnb, ~e.b);
    check({tag, "_qc"},  {3'b000, qc},  {3'b000, e.c});
    check({tag, "_qnc"}, {3'b000, qnc}, {3'b000, ~e.c});
  endtask

  // Rising-edge monitor: every edge must have an expectation queued.
  initial begin
    forever begin
      @(posedge C);
      #1;
      if (done) break;
      if (edge_q.size() == 0) begin
        check("edge_underflow", 4'h1, 4'h0);
      end else begin
        held = edge_q.pop_front();
        held_valid = 1;
        compare_all("edge", held);
      end
    end
  end

  // Falling-edge monitor: the stored value must not move between edges.
  initial begin
    forever begin
      @(negedge C);
      #1;
      if (held_valid && !done) compare_all("hold", held);
    end
  end

  // Reset monitor: asserting Rn clears the state without any clock edge.
  initial begin
    forever begin
      @(negedge Rn);
      #1;
      if (async_q.size() > 0) begin
        held = async_q.pop_front();
        compare_all("async_rst", held);
      end
    end
  end

  // Complement must hold at all times on every instance.
  always @(qa or qna or qb or qnb or qc or qnc) begin
    #0.5;
    check("inv_a", qna, ~qa);
    check("inv_b", qnb, ~qb);
    check("inv_c", {3'b000, qnc}, {3'b000, ~qc});
  end

  // One clock period of stimulus, starting right at a rising edge. D takes
  // its new value at d_off ns, Rn changes at rn_off ns, and an optional
  // glitch flips D during the low phase and restores it before the edge.
  task automatic run_cycle(input int d_off, input logic [W-1:0] d,
                           input int rn_off, input logic rn,
                           input bit glitch, input logic [W-1:0] gmask);
    fork
      begin
        #d_off;
        D = d;
      end
      begin
        if (rn !== Rn) begin
          #rn_off;
          if (!rn) async_q.push_back(model(1'b0, d));
          Rn = rn;
        end
      end
      begin
        if (glitch) begin
          #70;
          D = d ^ gmask;
          #5;
          D = d;
        end
      end
    join
    edge_q.push_back(model(rn, d));
    @(posedge C);
  endtask

  function automatic int pick_rn_off();
    int o;
    o = $urandom_range(1, 95);
    if (o >= 48 && o <= 52) o = 40;
    return o;
  endfunction

  initial begin
    logic [W-1:0] d;
    logic         rn;
    bit           g;
    logic [W-1:0] m;
    int           d_off;

    // Reset held with D=1 while C toggles.
    Rn = 1'b0;
    D  = '1;
    edge_q.push_back(model(1'b0, '1));
    @(posedge C);
    run_cycle(20, '1, 0, 1'b0, 0, '0);
    run_cycle(20, '1, 0, 1'b0, 0, '0);
    // Release in the low phase; the next edge captures D.
    run_cycle(20, '1, 70, 1'b1, 0, '0);

    // D low, then rising late in the low phase just before the edge.
    run_cycle(30, '0, 0, 1'b1, 0, '0);
    run_cycle(90, '1, 0, 1'b1, 0, '0);
    // D falls early in the high phase; held through the falling edge.
    run_cycle(10, '0, 0, 1'b1, 0, '0);
    // Pulse train.
    run_cycle(60, '1, 0, 1'b1, 0, '0);
    run_cycle(60, '0, 0, 1'b1, 0, '0);
    run_cycle(70, '1, 0, 1'b1, 0, '0);
    run_cycle(70, '0, 0, 1'b1, 0, '0);
    // D changing exactly on the falling edge.
    run_cycle(50, 4'h6, 0, 1'b1, 0, '0);
    // Glitches confined to the low phase.
    run_cycle(20, '1, 0, 1'b1, 1, 4'hF);
    run_cycle(20, '0, 0, 1'b1, 1, 4'h5);

    // Mid-cycle reset while Q is all ones, then release and a wide pattern.
    run_cycle(20, '1, 0, 1'b1, 0, '0);
    run_cycle(20, '1, 30, 1'b0, 0, '0);
    run_cycle(20, '1, 60, 1'b1, 0, '0);
    run_cycle(40, 4'hA, 0, 1'b1, 0, '0);

    // Randomised cycles.
    repeat (300) begin
      d  = W'($urandom);
      rn = Rn;
      if (Rn && $urandom_range(0, 19) == 0) rn = 1'b0;
      else if (!Rn && $urandom_range(0, 1) == 0) rn = 1'b1;
      g  = ($urandom_range(0, 3) == 0);
      m  = W'($urandom_range(1, 15));
      d_off = g ? $urandom_range(1, 65) : $urandom_range(1, 99);
      run_cycle(d_off, d, pick_rn_off(), rn, g, m);
    end

    #5;
    done = 1;
    if (edge_q.size() != 0) check("edge_q_leftover", 4'(edge_q.size()), 4'h0);
    if (async_q.size() != 0) check("async_q_leftover", 4'(async_q.size()), 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_d_trig
